// File: rtl/read_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : read_controller_pkg
// Description : Shared stream type for the UART request/response byte
//               streams seen by read_controller.
//               UART_PACKET fields:
//                 Source      - originator tag of the packet
//                 Destination - target tag of the packet
//                 Length      - number of bytes in the packet
//                 SoP / EoP   - first / last byte of a packet
//                 Data        - payload byte
//                 Valid       - byte qualifier
// Revision    : 1.0 - initial release
// ============================================================================
package read_controller_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } UART_PACKET;

endpackage
`default_nettype wire

// File: rtl/read_controller.sv
`default_nettype none
// ============================================================================
// Module      : read_controller
// Description : Serves register read requests that arrive on a UART packet
//               stream. A request is a start-of-packet byte whose Source
//               equals READ_SOURCE; its Data byte is the register address.
//               The controller strobes the register file once, captures the
//               32-bit word, and returns a packet made of the address byte
//               followed by DATA_LENGTH data bytes, most significant first.
//               Every transmitted byte is followed by one idle cycle so the
//               transmitter has time to raise its busy flag.
//
// Ports       : ipClk       - system clock, rising edge
//               ipReset     - synchronous active-high reset (registered
//                             once internally before use)
//               ipRxStream  - received request stream
//               ipRdData    - register data, valid one cycle after the strobe
//               ipTxBusy    - transmitter cannot take a byte
//               opRdEnable  - one-cycle read strobe
//               opRdAddress - register address being read
//               opTxStream  - response stream towards the transmitter
//
// Revision    : 1.0 - initial release
// ============================================================================
module read_controller
    import read_controller_pkg::*;
#(
    parameter int         DATA_LENGTH = 4,
    parameter logic [7:0] READ_SOURCE = 8'h00
) (
    input  logic        ipClk,
    input  logic        ipReset,
    input  UART_PACKET  ipRxStream,
    input  logic [31:0] ipRdData,
    input  logic        ipTxBusy,
    output logic        opRdEnable,
    output logic [7:0]  opRdAddress,
    output UART_PACKET  opTxStream
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_cnt_w     = $clog2(DATA_LENGTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_load  = c_cnt_w'(DATA_LENGTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(1);
    localparam logic [7:0]         c_tx_length = 8'(DATA_LENGTH + 1);
    localparam logic [7:0]         c_tx_dest   = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_SEND_ADDR = 3'd3,
        ST_SEND_DATA = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    logic               reset_q;

    state_t             state_q;
    state_t             state_d;
    // State entered when the one-cycle gap after a transmitted byte ends.
    state_t             return_q;
    state_t             return_d;

    logic               rd_enable_q;
    logic               rd_enable_d;
    logic [7:0]         rd_address_q;
    logic [7:0]         rd_address_d;

    logic [31:0]        shift_q;
    logic [31:0]        shift_d;
    logic [c_cnt_w-1:0] count_q;
    logic [c_cnt_w-1:0] count_d;

    UART_PACKET         tx_q;
    UART_PACKET         tx_d;

    logic               w_request;
    logic               w_last_byte;

    // Request fields that carry no meaning for a read request.
    logic               unused_rx_fields;
    assign unused_rx_fields = ^{ipRxStream.Destination, ipRxStream.Length,
                                ipRxStream.EoP};

    // ------------------------------------------------------------------------
    // Reset is retimed by one flop; everything else sees only reset_q.
    // ------------------------------------------------------------------------
    always_ff @(posedge ipClk) begin
        reset_q <= ipReset;
    end

    assign w_request   = ipRxStream.Valid && ipRxStream.SoP &&
                         (ipRxStream.Source == READ_SOURCE);
    assign w_last_byte = (count_q == c_cnt_last);

    // ------------------------------------------------------------------------
    // Next-state and output logic.
    // All outputs are registered: a byte decided in a SEND state (busy low)
    // becomes visible in the following cycle, which the FSM spends in GAP.
    // tx_d defaults to all-zero, so Valid can never stay high two cycles.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        return_d     = return_q;
        rd_enable_d  = 1'b0;
        rd_address_d = rd_address_q;
        shift_d      = shift_q;
        count_d      = count_q;
        tx_d         = '0;

        case (state_q)
            ST_IDLE: begin
                // Only SoP bytes with the read Source start a transaction;
                // anything arriving in other states is dropped.
                if (w_request) begin
                    rd_address_d = ipRxStream.Data;
                    rd_enable_d  = 1'b1;
                    state_d      = ST_READ;
                end
            end

            ST_READ: begin
                // opRdEnable is high during this cycle; the register file
                // answers in the next one.
                state_d = ST_CAPTURE;
            end

            ST_CAPTURE: begin
                shift_d = ipRdData;
                count_d = c_cnt_load;
                state_d = ST_SEND_ADDR;
            end

            ST_SEND_ADDR: begin
                if (!ipTxBusy) begin
                    tx_d.Valid       = 1'b1;
                    tx_d.SoP         = 1'b1;
                    tx_d.Source      = READ_SOURCE;
                    tx_d.Destination = c_tx_dest;
                    tx_d.Length      = c_tx_length;
                    tx_d.Data        = rd_address_q;
                    state_d          = ST_GAP;
                    return_d         = ST_SEND_DATA;
                end
            end

            ST_SEND_DATA: begin
                if (!ipTxBusy) begin
                    tx_d.Valid       = 1'b1;
                    tx_d.EoP         = w_last_byte;
                    tx_d.Source      = READ_SOURCE;
                    tx_d.Destination = c_tx_dest;
                    tx_d.Length      = c_tx_length;
                    tx_d.Data        = shift_q[31:24];
                    shift_d          = {shift_q[23:0], 8'h00};
                    count_d          = count_q - c_cnt_last;
                    state_d          = ST_GAP;
                    return_d         = w_last_byte ? ST_IDLE : ST_SEND_DATA;
                end
            end

            ST_GAP: begin
                state_d = return_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register. Reset drops any packet in flight without an EoP.
    // ------------------------------------------------------------------------
    always_ff @(posedge ipClk) begin
        if (reset_q) begin
            state_q      <= ST_IDLE;
            return_q     <= ST_IDLE;
            rd_enable_q  <= 1'b0;
            rd_address_q <= 8'h00;
            shift_q      <= 32'h0000_0000;
            count_q      <= '0;
            tx_q         <= '0;
        end else begin
            state_q      <= state_d;
            return_q     <= return_d;
            rd_enable_q  <= rd_enable_d;
            rd_address_q <= rd_address_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            tx_q         <= tx_d;
        end
    end

    assign opRdEnable  = rd_enable_q;
    assign opRdAddress = rd_address_q;
    assign opTxStream  = tx_q;

endmodule
`default_nettype wire
